// File: rtl/clint_axil.sv
// Core-local interruptor with an AXI4-Lite slave port: prescaled 64-bit mtime,
// per-hart mtimecmp and msip, and the mtip/msip interrupt lines they drive.
module clint_axil #(
    parameter int unsigned NHART    = 1,
    parameter logic [31:0] BASE     = 32'ha000_0000,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      araddr,
    input  logic             arvalid,
    output logic             arready,
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rvalid,
    input  logic             rready,
    input  logic [31:0]      awaddr,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wvalid,
    output logic             wready,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    output logic [NHART-1:0] mtip,
    output logic [NHART-1:0] msip
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {RIdle, RResp} r_state_t;
    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;

    logic [PW-1:0] presc;
    logic          tick;
    logic [63:0]   mtime, mtime_inc, mtime_d;
    logic [63:0]   mtimecmp [NHART];

    logic [31:0] roff, rd_val;
    logic        rd_ok;

    logic [31:0] aw_lat, wd_lat;
    logic [3:0]  ws_lat;
    logic        wr_en, wr_ok;
    logic [31:0] wr_addr, woff, wr_data;
    logic [3:0]  wr_strb;
    logic [NHART-1:0] wr_msip, wr_cmp_lo, wr_cmp_hi;
    logic        wr_mt_lo, wr_mt_hi;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        end
        return res;
    endfunction

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign arready = (r_state == RIdle);
    assign rvalid  = (r_state == RResp);
    assign awready = (w_state == WIdle) || (w_state == WAddr);
    assign wready  = (w_state == WIdle) || (w_state == WData);
    assign bvalid  = (w_state == WResp);

    // Unaligned offsets never match an entry, so they fall through to SLVERR.
    always_comb begin
        roff   = araddr - BASE;
        rd_val = 32'h0;
        rd_ok  = 1'b0;
        for (int h = 0; h < NHART; h++) begin
            if (roff == 32'(4 * h)) begin
                rd_ok  = 1'b1;
                rd_val = {31'h0, msip[h]};
            end
            if (roff == 32'h4000 + 32'(8 * h)) begin
                rd_ok  = 1'b1;
                rd_val = mtimecmp[h][31:0];
            end
            if (roff == 32'h4004 + 32'(8 * h)) begin
                rd_ok  = 1'b1;
                rd_val = mtimecmp[h][63:32];
            end
        end
        if (roff == 32'h0000_bff8) begin
            rd_ok  = 1'b1;
            rd_val = mtime[31:0];
        end
        if (roff == 32'h0000_bffc) begin
            rd_ok  = 1'b1;
            rd_val = mtime[63:32];
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            RIdle: if (arvalid) r_next = RResp;
            RResp: if (rready) r_next = RIdle;
            default: r_next = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RIdle;
            rdata   <= 32'h0;
            rresp   <= 2'b00;
        end else begin
            r_state <= r_next;
            if (r_state == RIdle && arvalid) begin
                rdata <= rd_val;
                rresp <= rd_ok ? 2'b00 : 2'b10;
            end
        end
    end

    always_comb begin
        w_next = w_state;
        wr_en  = 1'b0;
        unique case (w_state)
            WIdle: begin
                if (awvalid && wvalid) begin
                    wr_en  = 1'b1;
                    w_next = WResp;
                end else if (awvalid) begin
                    w_next = WData;
                end else if (wvalid) begin
                    w_next = WAddr;
                end
            end
            WAddr: if (awvalid) begin
                wr_en  = 1'b1;
                w_next = WResp;
            end
            WData: if (wvalid) begin
                wr_en  = 1'b1;
                w_next = WResp;
            end
            WResp: if (bready) w_next = WIdle;
            default: w_next = WIdle;
        endcase
    end

    // Whichever half of the write arrived first comes from its latch.
    assign wr_addr = (w_state == WData) ? aw_lat : awaddr;
    assign wr_data = (w_state == WAddr) ? wd_lat : wdata;
    assign wr_strb = (w_state == WAddr) ? ws_lat : wstrb;

    always_comb begin
        woff      = wr_addr - BASE;
        wr_ok     = 1'b0;
        wr_msip   = '0;
        wr_cmp_lo = '0;
        wr_cmp_hi = '0;
        wr_mt_lo  = 1'b0;
        wr_mt_hi  = 1'b0;
        for (int h = 0; h < NHART; h++) begin
            if (woff == 32'(4 * h)) begin
                wr_ok      = 1'b1;
                wr_msip[h] = wr_en;
            end
            if (woff == 32'h4000 + 32'(8 * h)) begin
                wr_ok        = 1'b1;
                wr_cmp_lo[h] = wr_en;
            end
            if (woff == 32'h4004 + 32'(8 * h)) begin
                wr_ok        = 1'b1;
                wr_cmp_hi[h] = wr_en;
            end
        end
        if (woff == 32'h0000_bff8) begin
            wr_ok    = 1'b1;
            wr_mt_lo = wr_en;
        end
        if (woff == 32'h0000_bffc) begin
            wr_ok    = 1'b1;
            wr_mt_hi = wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= WIdle;
            aw_lat  <= 32'h0;
            wd_lat  <= 32'h0;
            ws_lat  <= 4'h0;
            bresp   <= 2'b00;
        end else begin
            w_state <= w_next;
            if (w_state == WIdle && awvalid && !wvalid) aw_lat <= awaddr;
            if (w_state == WIdle && wvalid && !awvalid) begin
                wd_lat <= wdata;
                ws_lat <= wstrb;
            end
            if (wr_en) bresp <= wr_ok ? 2'b00 : 2'b10;
        end
    end

    // Bus writes override the tick only on the bytes they touch.
    always_comb begin
        mtime_inc = tick ? mtime + 64'd1 : mtime;
        mtime_d   = mtime_inc;
        if (wr_mt_lo) mtime_d[31:0]  = merge(mtime_inc[31:0], wr_data, wr_strb);
        if (wr_mt_hi) mtime_d[63:32] = merge(mtime_inc[63:32], wr_data, wr_strb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            mtime <= 64'h0;
            msip  <= '0;
            mtip  <= '0;
            for (int h = 0; h < NHART; h++) mtimecmp[h] <= '1;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            mtime <= mtime_d;
            for (int h = 0; h < NHART; h++) begin
                if (wr_cmp_lo[h]) mtimecmp[h][31:0]  <= merge(mtimecmp[h][31:0], wr_data, wr_strb);
                if (wr_cmp_hi[h]) mtimecmp[h][63:32] <= merge(mtimecmp[h][63:32], wr_data, wr_strb);
                if (wr_msip[h] && wr_strb[0]) msip[h] <= wr_data[0];
                mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

endmodule

// File: doc/clint_axil.md
Name: clint_axil

Overview:
- Parametrised core-local interruptor, successor of the single-hart read-only timer.
- AXI4-Lite slave, 32-bit data, full read and write channels.
- Provides a prescaled 64-bit mtime, a 64-bit mtimecmp and a msip bit per hart.
- Drives per-hart timer (mtip) and software (msip) interrupt lines into the cores.

Parameters:
- NHART, 1, number of harts (1..16).
- BASE, 32'ha000_0000, base address of the block.
- TICK_DIV, 1, clk cycles per mtime increment (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- mtip  out  NHART  timer interrupt per hart
- msip  out  NHART  software interrupt per hart

Behaviour:
- Address map (offset = addr-BASE):
  - msip[h] at 0x0000+4h; bit0 is meaningful, upper bits read as 0.
  - mtimecmp[h] lo/hi at 0x4000+8h / 0x4004+8h.
  - mtime lo/hi at 0xBFF8 / 0xBFFC.
- Any other offset, or addr[1:0]!=0: SLVERR (2'b10), read data 0, write ignored. Otherwise OKAY (2'b00).
- Reset values:
  - mtime=0, prescaler=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, msip[*]=0, mtip=0.
  - arready=1, awready=1, wready=1; rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - mtime increments by 1 in the cycle the prescaler equals TICK_DIV-1; the prescaler wraps to 0.
  - mtime wraps from 2^64-1 to 0.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready=1. On arvalid, capture the decoded data/resp into rdata/rresp and go to R_RESP.
  - R_RESP: arready=0, rvalid=1. rdata/rresp are held stable until rready, then return to R_IDLE.
  - Read data is the register value at the AR handshake cycle. One-cycle latency AR->R.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
  - W_IDLE: awready=wready=1.
    - AW and W in the same cycle: perform the write, go to W_RESP.
    - AW only: latch awaddr, go to W_DATA (wready=1, awready=0).
    - W only: latch wdata/wstrb, go to W_ADDR (awready=1, wready=0).
  - W_ADDR / W_DATA: on the missing handshake, perform the write, go to W_RESP.
  - W_RESP: awready=wready=0, bvalid=1, bresp held until bready, then go to W_IDLE.
- Write semantics:
  - Byte-granular per wstrb.
  - msip takes only wdata[0] when wstrb[0]=1.
  - A write to mtime in the same cycle as a tick: the written bytes win, unwritten bytes take the incremented value.
  - 32-bit halves are written independently; there is no atomic 64-bit update.
- Interrupts:
  - mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit.
  - mtip updates one cycle after mtime or mtimecmp changes.
  - msip output = msip register bit.
- Read and write channels are independent and may complete in the same cycle.
- Reset mid-transaction aborts all pending handshakes and returns to the reset state next cycle.

Test Plan:
- Reset, TICK_DIV=1; read 0xBFF8 at cycle 10 after reset -> rvalid next cycle, rdata≈10 (exact per bench timing), rresp=00; rdata stable while rready held low 3 cycles.
- TICK_DIV=4; 40 cycles after reset, read mtime lo -> 10; read mtime hi -> 0.
- NHART=2: write mtimecmp[1] lo=0x20, hi=0 -> bresp=00; mtip=2'b10 by the cycle after mtime reaches 0x20, and mtip[0] stays 0.
- Write msip[0] wdata=1 with wstrb=4'b0001 -> msip=1; write with wstrb=0 -> unchanged; write wdata=0 -> msip=0.
- AW issued 3 cycles before W -> wready=1, awready=0 in between; single bvalid. W issued before AW behaves symmetrically.
- Read 0x1000 and write 0xBFF9 -> rresp=10 with rdata=0; bresp=10 with no state change. Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> wraps to 0 after the next tick.
